// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath and its controller: default widths,
// register-address width and the command encoding.
package fir_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefNRegs = 16;
  localparam int unsigned AddrW    = 4;

  typedef enum logic [2:0] {
    OpNop        = 3'b000,
    OpCopy       = 3'b001,
    OpLoadSample = 3'b010,
    OpLoadCoef   = 3'b011,
    OpAdd        = 3'b100,
    OpSub        = 3'b101,
    OpMul        = 3'b110,
    OpRsvd       = 3'b111
  } fir_op_e;

  // True for every command that commits a result to the register file.
  function automatic logic is_write_op(fir_op_e op);
    return !((op == OpNop) || (op == OpRsvd));
  endfunction

endpackage

// File: rtl/fir_regfile.sv
// FIR register file: NREGS x DATA_W storage, two combinational read ports,
// one synchronous write port and a synchronous clear that wins over the write.
module fir_regfile
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned NREGS  = DefNRegs
) (
  input  logic              clk,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic [AddrW-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AddrW-1:0]  i_raddr1,
  input  logic [AddrW-1:0]  i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2,
  output logic [DATA_W-1:0] o_reg0
);

  logic [DATA_W-1:0] r_regs [NREGS];

  // Storage update: clear has priority, out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (32'(i_waddr) < NREGS)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read ports see the pre-write state; unimplemented addresses read as zero.
  always_comb begin
    o_rdata1 = '0;
    o_rdata2 = '0;
    if (32'(i_raddr1) < NREGS) o_rdata1 = r_regs[i_raddr1];
    if (32'(i_raddr2) < NREGS) o_rdata2 = r_regs[i_raddr2];
  end

  assign o_reg0 = r_regs[0];

endmodule

// File: rtl/fir_datapath.sv
// FIR datapath: register file plus a combinational ALU (copy, load, add, sub,
// mul) with signed-overflow detection. Results commit one cycle after the op.
// Build option: define FIR_DP_SAT_EN to saturate overflowing results instead
// of wrapping them; the overflow flag is raised either way.
module fir_datapath
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned NREGS  = DefNRegs
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        op,
  input  logic [AddrW-1:0]  src1,
  input  logic [AddrW-1:0]  src2,
  input  logic [AddrW-1:0]  dest,
  input  logic [DATA_W-1:0] ext_data1,
  input  logic [DATA_W-1:0] ext_data2,
  output logic [DATA_W-1:0] outreg_data,
  output logic              overflow
);

`ifdef FIR_DP_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  localparam logic [DATA_W-1:0] SatMax = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SatMin = {1'b1, {(DATA_W-1){1'b0}}};

  fir_op_e             w_op;
  logic [DATA_W-1:0]   w_rd1;
  logic [DATA_W-1:0]   w_rd2;
  logic [DATA_W-1:0]   w_sum;
  logic [DATA_W-1:0]   w_diff;
  logic [2*DATA_W-1:0] w_a_ext;
  logic [2*DATA_W-1:0] w_b_ext;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W:0]     w_prod_hi;
  logic                w_add_ovf;
  logic                w_sub_ovf;
  logic                w_mul_ovf;
  logic [DATA_W-1:0]   w_raw;
  logic                w_sat_neg;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_we;

  assign w_op = fir_op_e'(op);

  fir_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk      (clk),
    .i_clr    (rst),
    .i_we     (w_we),
    .i_waddr  (dest),
    .i_wdata  (w_wdata),
    .i_raddr1 (src1),
    .i_raddr2 (src2),
    .o_rdata1 (w_rd1),
    .o_rdata2 (w_rd2),
    .o_reg0   (outreg_data)
  );

  // Arithmetic units: all operands are two's-complement signed.
  always_comb begin
    w_sum     = w_rd1 + w_rd2;
    w_diff    = w_rd1 - w_rd2;
    // Sign-extending to 2*DATA_W makes the truncated product the exact signed one.
    w_a_ext   = {{DATA_W{w_rd1[DATA_W-1]}}, w_rd1};
    w_b_ext   = {{DATA_W{w_rd2[DATA_W-1]}}, w_rd2};
    w_prod    = w_a_ext * w_b_ext;
    w_prod_hi = w_prod[2*DATA_W-1:DATA_W-1];
    w_add_ovf = (w_rd1[DATA_W-1] == w_rd2[DATA_W-1]) &&
                (w_sum[DATA_W-1] != w_rd1[DATA_W-1]);
    w_sub_ovf = (w_rd1[DATA_W-1] != w_rd2[DATA_W-1]) &&
                (w_diff[DATA_W-1] != w_rd1[DATA_W-1]);
    // Product fits only if the top DATA_W+1 bits are a pure sign extension.
    w_mul_ovf = !((&w_prod_hi) || !(|w_prod_hi));
  end

  // Command decode: select the raw result, overflow flag and saturation direction.
  always_comb begin
    w_raw     = '0;
    overflow  = 1'b0;
    w_sat_neg = 1'b0;
    unique case (w_op)
      OpNop:        ;
      OpCopy:       w_raw = w_rd1;
      OpLoadSample: w_raw = ext_data1;
      OpLoadCoef:   w_raw = ext_data2;
      OpAdd: begin
        w_raw     = w_sum;
        overflow  = w_add_ovf;
        w_sat_neg = w_rd1[DATA_W-1];
      end
      OpSub: begin
        w_raw     = w_diff;
        overflow  = w_sub_ovf;
        w_sat_neg = w_rd1[DATA_W-1];
      end
      OpMul: begin
        w_raw     = w_prod[DATA_W-1:0];
        overflow  = w_mul_ovf;
        w_sat_neg = w_prod[2*DATA_W-1];
      end
      OpRsvd:       ;
    endcase
  end

  // Write-back: wrap by default, clamp on overflow when saturation is built in.
  always_comb begin
    w_wdata = w_raw;
    if (SatEn && overflow) begin
      w_wdata = w_sat_neg ? SatMin : SatMax;
    end
    w_we = is_write_op(w_op) && !rst;
  end

endmodule

// File: tb/tb_fir_datapath.sv
// Self-checking bench for fir_datapath: directed scenarios plus randomized
// commands compared against an integer-arithmetic register model.
module tb_fir_datapath;

  localparam int unsigned DW = 16;

  localparam logic [2:0] NOP = 3'd0, COPY = 3'd1, LDS = 3'd2, LDC = 3'd3;
  localparam logic [2:0] ADD = 3'd4, SUB = 3'd5, MUL = 3'd6, RSV = 3'd7;

`ifdef FIR_DP_SAT_EN
  localparam logic [DW-1:0] EXP_ADD_OVF = 16'h7FFF, EXP_SUB_OVF = 16'h8000;
  localparam logic [DW-1:0] EXP_MUL_POS = 16'h7FFF, EXP_MUL_NEG = 16'h8000;
`else
  localparam logic [DW-1:0] EXP_ADD_OVF = 16'h8000, EXP_SUB_OVF = 16'h7FFF;
  localparam logic [DW-1:0] EXP_MUL_POS = 16'h0000, EXP_MUL_NEG = 16'h0000;
`endif

  logic          clk, rst;
  logic [2:0]    op;
  logic [3:0]    src1, src2, dest;
  logic [DW-1:0] ext_data1, ext_data2, outreg_data;
  logic          overflow;

  int n_checks, n_errors;

  logic [DW-1:0] m_regs [16];
  logic [DW-1:0] exp_res;
  logic          exp_ovf, exp_we;

  fir_datapath #(
    .DATA_W (16),
    .NREGS  (16)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .src1        (src1),
    .src2        (src2),
    .dest        (dest),
    .ext_data1   (ext_data1),
    .ext_data2   (ext_data2),
    .outreg_data (outreg_data),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: evaluate the current command with plain integer arithmetic.
  task automatic model_eval();
    int a, b, full;
    a = int'($signed(m_regs[src1]));
    b = int'($signed(m_regs[src2]));
    full = 0;
    exp_we = 1'b1;
    exp_ovf = 1'b0;
    exp_res = '0;
    case (op)
      NOP, RSV: exp_we = 1'b0;
      COPY:     exp_res = m_regs[src1];
      LDS:      exp_res = ext_data1;
      LDC:      exp_res = ext_data2;
      default: begin
        if (op == ADD) full = a + b;
        else if (op == SUB) full = a - b;
        else full = a * b;
        exp_ovf = (full > 32767) || (full < -32768);
        exp_res = full[15:0];
`ifdef FIR_DP_SAT_EN
        if (exp_ovf) exp_res = (full > 0) ? 16'h7FFF : 16'h8000;
`endif
      end
    endcase
  endtask

  // Apply a command and settle to mid-cycle, away from the clock edges.
  task automatic drive(input logic [2:0] o, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] d, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    op = o; src1 = s1; src2 = s2; dest = d; ext_data1 = e1; ext_data2 = e2;
    model_eval();
    #3;
  endtask

  // Clock edge: commit into the model exactly what the hardware should commit.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
    end else if (exp_we) begin
      m_regs[dest] = exp_res;
    end
    #1;
  endtask

  task automatic load(input logic [3:0] d, input logic [DW-1:0] v);
    drive(LDS, 4'd0, 4'd0, d, v, 16'h0);
    tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) load(4'(i), 16'($urandom) | 16'h0001);
    rst = 1'b1;
    drive(LDS, 4'd0, 4'd0, 4'd0, 16'hBEEF, 16'h0);
    tick();
    rst = 1'b0;
    drive(NOP, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0);
    n_checks++;
    if (outreg_data !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_outreg: got %h expected 0000", outreg_data);
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ovf: got %b expected 0", overflow);
    end
    for (int r = 1; r < 16; r++) begin
      drive(COPY, 4'(r), 4'd0, 4'd0, 16'h0, 16'h0);
      tick();
      n_checks++;
      if (outreg_data !== 16'h0000) begin
        n_errors++;
        $display("FAIL reset_reg%0d: got %h expected 0000", r, outreg_data);
      end
    end
  endtask

  task automatic test_load();
    drive(LDC, 4'd0, 4'd0, 4'd6, 16'h1111, 16'h0003);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL load_coef_ovf: got %b expected 0", overflow);
    end
    tick();
    drive(COPY, 4'd6, 4'd0, 4'd1, 16'h0, 16'h0);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL copy_ovf: got %b expected 0", overflow);
    end
    tick();
    drive(COPY, 4'd1, 4'd0, 4'd0, 16'h0, 16'h0);
    tick();
    n_checks++;
    if (outreg_data !== 16'h0003) begin
      n_errors++;
      $display("FAIL load_copy_r1: got %h expected 0003", outreg_data);
    end
  endtask

  task automatic test_mac();
    load(4'd1, 16'h0004);
    load(4'd6, 16'h0005);
    load(4'd0, 16'h0000);
    drive(MUL, 4'd1, 4'd6, 4'd10, 16'h0, 16'h0);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL mac_mul_ovf: got %b expected 0", overflow);
    end
    tick();
    drive(ADD, 4'd0, 4'd10, 4'd0, 16'h0, 16'h0);
    tick();
    n_checks++;
    if (outreg_data !== 16'h0014) begin
      n_errors++;
      $display("FAIL mac_result: got %h expected 0014", outreg_data);
    end
  endtask

  task automatic test_add_overflow();
    load(4'd1, 16'h7FFF);
    load(4'd2, 16'h0001);
    drive(ADD, 4'd1, 4'd2, 4'd0, 16'h0, 16'h0);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL add_ovf_flag: got %b expected 1", overflow);
    end
    tick();
    n_checks++;
    if (outreg_data !== EXP_ADD_OVF) begin
      n_errors++;
      $display("FAIL add_ovf_result: got %h expected %h", outreg_data, EXP_ADD_OVF);
    end
    load(4'd1, 16'h8000);
    drive(SUB, 4'd1, 4'd2, 4'd0, 16'h0, 16'h0);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL sub_ovf_flag: got %b expected 1", overflow);
    end
    tick();
    n_checks++;
    if (outreg_data !== EXP_SUB_OVF) begin
      n_errors++;
      $display("FAIL sub_ovf_result: got %h expected %h", outreg_data, EXP_SUB_OVF);
    end
  endtask

  task automatic test_mul_overflow();
    load(4'd1, 16'h0100);
    load(4'd2, 16'h0100);
    drive(MUL, 4'd1, 4'd2, 4'd0, 16'h0, 16'h0);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL mul_ovf_flag: got %b expected 1", overflow);
    end
    tick();
    n_checks++;
    if (outreg_data !== EXP_MUL_POS) begin
      n_errors++;
      $display("FAIL mul_ovf_result: got %h expected %h", outreg_data, EXP_MUL_POS);
    end
    load(4'd1, 16'hFFFF);
    load(4'd2, 16'h0002);
    drive(MUL, 4'd1, 4'd2, 4'd0, 16'h0, 16'h0);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL mul_neg_flag: got %b expected 0", overflow);
    end
    tick();
    n_checks++;
    if (outreg_data !== 16'hFFFE) begin
      n_errors++;
      $display("FAIL mul_neg_result: got %h expected fffe", outreg_data);
    end
    load(4'd1, 16'h8000);
    drive(MUL, 4'd1, 4'd2, 4'd0, 16'h0, 16'h0);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL mul_negovf_flag: got %b expected 1", overflow);
    end
    tick();
    n_checks++;
    if (outreg_data !== EXP_MUL_NEG) begin
      n_errors++;
      $display("FAIL mul_negovf_result: got %h expected %h", outreg_data, EXP_MUL_NEG);
    end
  endtask

  task automatic test_hazard();
    load(4'd0, 16'h1234);
    drive(SUB, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0);
    n_checks++;
    if (outreg_data !== 16'h1234) begin
      n_errors++;
      $display("FAIL hazard_same_cycle: got %h expected 1234", outreg_data);
    end
    tick();
    n_checks++;
    if (outreg_data !== 16'h0000) begin
      n_errors++;
      $display("FAIL hazard_next_cycle: got %h expected 0000", outreg_data);
    end
  endtask

  task automatic test_nop_rsvd();
    load(4'd1, 16'h7FFF);
    load(4'd2, 16'h7FFF);
    load(4'd0, 16'h5A5A);
    drive(RSV, 4'd1, 4'd2, 4'd0, 16'hDEAD, 16'hBEEF);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL rsvd_ovf: got %b expected 0", overflow);
    end
    tick();
    drive(NOP, 4'd1, 4'd2, 4'd0, 16'hDEAD, 16'hBEEF);
    tick();
    n_checks++;
    if (outreg_data !== 16'h5A5A) begin
      n_errors++;
      $display("FAIL nop_rsvd_nowrite: got %h expected 5a5a", outreg_data);
    end
  endtask

  task automatic test_reset_mid();
    load(4'd1, 16'h0004);
    load(4'd6, 16'h0005);
    load(4'd0, 16'h0007);
    drive(MUL, 4'd1, 4'd6, 4'd10, 16'h0, 16'h0);
    tick();
    rst = 1'b1;
    drive(ADD, 4'd0, 4'd10, 4'd0, 16'h0, 16'h0);
    tick();
    rst = 1'b0;
    drive(NOP, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0);
    n_checks++;
    if (outreg_data !== 16'h0000) begin
      n_errors++;
      $display("FAIL rstmid_r0: got %h expected 0000", outreg_data);
    end
    drive(COPY, 4'd10, 4'd0, 4'd0, 16'h0, 16'h0);
    tick();
    n_checks++;
    if (outreg_data !== 16'h0000) begin
      n_errors++;
      $display("FAIL rstmid_r10: got %h expected 0000", outreg_data);
    end
  endtask

  task automatic test_random();
    logic [3:0]    d;
    logic [DW-1:0] e1, e2;
    for (int i = 0; i < 300; i++) begin
      d  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      e1 = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) - 16'd128 : 16'($urandom);
      e2 = 16'($urandom);
      drive(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            d, e1, e2);
      n_checks++;
      if (overflow !== exp_ovf) begin
        n_errors++;
        $display("FAIL random_ovf iter %0d op %0d: got %b expected %b", i, op, overflow, exp_ovf);
      end
      tick();
      n_checks++;
      if (outreg_data !== m_regs[0]) begin
        n_errors++;
        $display("FAIL random_r0 iter %0d: got %h expected %h", i, outreg_data, m_regs[0]);
      end
    end
    for (int r = 15; r >= 1; r--) begin
      drive(COPY, 4'(r), 4'd0, 4'd0, 16'h0, 16'h0);
      tick();
      n_checks++;
      if (outreg_data !== m_regs[0]) begin
        n_errors++;
        $display("FAIL random_final_r%0d: got %h expected %h", r, outreg_data, m_regs[0]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    rst = 1'b1;
    drive(NOP, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0);
    tick();
    tick();
    rst = 1'b0;

    test_reset();
    test_load();
    test_mac();
    test_add_overflow();
    test_mul_overflow();
    test_hazard();
    test_nop_rsvd();
    test_reset_mid();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
